// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
//   GROUP_W     : width of one lookahead group (4 bits)
//   op_mode_t   : per-operation mode, OP_ADD (A+B) or OP_SUB (A+~B+1)
//   alu_flags_t : registered result flags {n, z, v}
//   signed_ovf  : two's-complement overflow from the MSBs of both operands
//                 (B already conditioned for subtract) and the raw sum
// -----------------------------------------------------------------------------
package cla_pkg;

  localparam int GROUP_W = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_mode_t;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
  } alu_flags_t;

  // Overflow happens only when both addends share a sign and the raw sum
  // comes out with the opposite sign.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/cla_group4.sv
// -----------------------------------------------------------------------------
// cla_group4
// Purely combinational 4-bit carry-lookahead group.
// Ports:
//   a, b  in  [3:0]  group operand bits (b already conditioned for subtract)
//   cin   in         carry into the group
//   sum   out [3:0]  group sum bits
//   p     out        group propagate (all four bit positions propagate)
//   g     out        group generate (group produces a carry on its own)
//   cout  out        carry out of the group, g | (p & cin)
// p and g do not depend on cin, so the parent can build inter-group
// lookahead from them without a combinational loop through this block.
// -----------------------------------------------------------------------------
module cla_group4
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  output logic [GROUP_W-1:0] sum,
  output logic               p,
  output logic               g,
  output logic               cout
);

  logic [GROUP_W-1:0] bit_p;
  logic [GROUP_W-1:0] bit_g;
  logic [GROUP_W-1:0] carry;

  assign bit_p = a ^ b;
  assign bit_g = a & b;

  // Flat lookahead equations: every internal carry is two logic levels
  // from the bit P/G terms and cin.
  assign carry[0] = cin;
  assign carry[1] = bit_g[0] | (bit_p[0] & cin);
  assign carry[2] = bit_g[1] | (bit_p[1] & bit_g[0])
                  | (bit_p[1] & bit_p[0] & cin);
  assign carry[3] = bit_g[2] | (bit_p[2] & bit_g[1])
                  | (bit_p[2] & bit_p[1] & bit_g[0])
                  | (bit_p[2] & bit_p[1] & bit_p[0] & cin);

  assign p = &bit_p;
  assign g = bit_g[3] | (bit_p[3] & bit_g[2])
           | (bit_p[3] & bit_p[2] & bit_g[1])
           | (bit_p[3] & bit_p[2] & bit_p[1] & bit_g[0]);

  assign cout = g | (p & cin);
  assign sum  = bit_p ^ carry;

endmodule

// File: rtl/cla_addsub_pipe.sv
// -----------------------------------------------------------------------------
// cla_addsub_pipe
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// The WIDTH-bit operation is split into 4-bit lookahead groups; each of the
// STAGES pipeline stages resolves GPS = WIDTH/4/STAGES groups and hands the
// group carry to the next stage through a register.
//
// Parameters:
//   WIDTH   operand/result width, multiple of 4
//   STAGES  pipeline depth (latency in cycles), must divide WIDTH/4
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset, discards in-flight ops
//   in_valid   in   operation offered
//   in_ready   out  operation accepted this cycle
//   a, b       in   [WIDTH-1:0] operands
//   sub        in   0 = A+B, 1 = A-B (A + ~B + 1)
//   out_valid  out  result valid
//   out_ready  in   downstream accepts the result
//   sum        out  [WIDTH-1:0] result
//   cout       out  carry out of the MSB group (raw operation)
//   flag_n     out  sum[WIDTH-1]
//   flag_z     out  sum == 0
//   flag_v     out  signed overflow of the raw operation
//
// Build option:
//   CLA_SATURATE_EN  when defined, an overflowing result is clamped to the
//                    most positive / most negative value (chosen by the sign
//                    of A); n and z follow the clamped sum, cout and v still
//                    describe the raw operation.
// -----------------------------------------------------------------------------
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v
);

  localparam int NG  = WIDTH / GROUP_W;            // total groups
  localparam int GPS = NG / STAGES;                // groups per stage
  localparam int NR  = (STAGES > 1) ? STAGES - 1 : 1; // intermediate ranks
  localparam int LS  = STAGES - 1;                 // last stage index

  // ---------------------------------------------------------------------------
  // Handshake: the whole pipe moves as one (global stall), bubbles included.
  // ---------------------------------------------------------------------------
  logic advance;
  logic out_valid_reg;

  assign advance  = out_ready | ~out_valid_reg;
  assign in_ready = advance & ~rst;

  // ---------------------------------------------------------------------------
  // Per-stage inputs and results. Stage 0 reads the ports directly; stage k
  // reads the intermediate register rank k-1.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] st_a [STAGES];
  logic [WIDTH-1:0] st_b [STAGES];
  logic [WIDTH-1:0] st_s [STAGES];
  logic             st_c [STAGES];
  logic             st_v [STAGES];

  logic [WIDTH-1:0] nx_s [STAGES];
  logic             nx_c [STAGES];

  // Intermediate register ranks (between stage k and stage k+1).
  logic [WIDTH-1:0] pl_a_reg [NR];
  logic [WIDTH-1:0] pl_b_reg [NR];
  logic [WIDTH-1:0] pl_s_reg [NR];
  logic             pl_c_reg [NR];
  logic             pl_v_reg [NR];

  // B is conditioned once at entry so every later stage only ever adds.
  assign st_a[0] = a;
  assign st_b[0] = (op_mode_t'(sub) == OP_SUB) ? ~b : b;
  assign st_c[0] = (op_mode_t'(sub) == OP_SUB);
  assign st_s[0] = '0;
  assign st_v[0] = in_valid;

  genvar gi;
  generate
    for (gi = 1; gi < STAGES; gi++) begin : g_link
      assign st_a[gi] = pl_a_reg[gi-1];
      assign st_b[gi] = pl_b_reg[gi-1];
      assign st_s[gi] = pl_s_reg[gi-1];
      assign st_c[gi] = pl_c_reg[gi-1];
      assign st_v[gi] = pl_v_reg[gi-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Lookahead groups. Group gi belongs to stage gi/GPS. The first group of a
  // stage takes the carry registered by the previous stage; the others take
  // a carry formed from the neighbouring group's P/G.
  // ---------------------------------------------------------------------------
  logic [GROUP_W-1:0] grp_sum  [NG];
  logic               grp_p    [NG];
  logic               grp_g    [NG];
  logic               grp_cin  [NG];
  logic               grp_cout [NG];

  generate
    for (gi = 0; gi < NG; gi++) begin : g_grp
      localparam int STG = gi / GPS;

      if ((gi % GPS) == 0) begin : g_first
        assign grp_cin[gi] = st_c[STG];
      end else begin : g_chain
        assign grp_cin[gi] = grp_g[gi-1] | (grp_p[gi-1] & grp_cin[gi-1]);
      end

      cla_group4 u_grp (
        .a    (st_a[STG][gi*GROUP_W +: GROUP_W]),
        .b    (st_b[STG][gi*GROUP_W +: GROUP_W]),
        .cin  (grp_cin[gi]),
        .sum  (grp_sum[gi]),
        .p    (grp_p[gi]),
        .g    (grp_g[gi]),
        .cout (grp_cout[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stage results: lower sum bits pass through, this stage's slice is filled
  // from its groups, and the carry out of its top group moves on.
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [WIDTH-1:0] stage_sum;

      always_comb begin
        stage_sum = st_s[gi];
        for (int j = 0; j < GPS; j++) begin
          stage_sum[(gi*GPS + j)*GROUP_W +: GROUP_W] = grp_sum[gi*GPS + j];
        end
      end

      assign nx_s[gi] = stage_sum;
      assign nx_c[gi] = grp_cout[(gi+1)*GPS - 1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Intermediate ranks. Data travels with bubbles too; only the valid bit
  // decides whether anything downstream cares. Acceptance needs no separate
  // term: whenever advance is high and rst is low, in_ready is high.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        pl_v_reg[k] <= 1'b0;
        pl_a_reg[k] <= '0;
        pl_b_reg[k] <= '0;
        pl_s_reg[k] <= '0;
        pl_c_reg[k] <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        pl_v_reg[k] <= st_v[k];
        pl_a_reg[k] <= st_a[k];
        pl_b_reg[k] <= st_b[k];
        pl_s_reg[k] <= nx_s[k];
        pl_c_reg[k] <= nx_c[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Final stage: flags and optional clamp are formed before the output
  // register so that every output comes straight from a flop.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] final_sum;
  logic             a_msb;
  logic             b_msb;
  logic             raw_ovf;
  alu_flags_t       flags_next;

  assign raw_sum = nx_s[LS];
  assign a_msb   = st_a[LS][WIDTH-1];
  assign b_msb   = st_b[LS][WIDTH-1];
  assign raw_ovf = signed_ovf(a_msb, b_msb, raw_sum[WIDTH-1]);

`ifdef CLA_SATURATE_EN
  // Overflow toward the sign of A: positive A clamps to max, negative to min.
  assign final_sum = !raw_ovf ? raw_sum
                   : (a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                            : {1'b0, {(WIDTH-1){1'b1}}});
`else
  assign final_sum = raw_sum;
`endif

  always_comb begin
    flags_next   = '0;
    flags_next.n = final_sum[WIDTH-1];
    flags_next.z = (final_sum == '0);
    flags_next.v = raw_ovf;
  end

  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  alu_flags_t       flags_reg;

  // Result registers only load on a real operation so that they hold the
  // last result while out_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      flags_reg     <= '0;
    end else if (advance) begin
      out_valid_reg <= st_v[LS];
      if (st_v[LS]) begin
        sum_reg   <= final_sum;
        cout_reg  <= nx_c[LS];
        flags_reg <= flags_next;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign flag_n    = flags_reg.n;
  assign flag_z    = flags_reg.z;
  assign flag_v    = flags_reg.v;

endmodule

// File: doc/cla_addsub_pipe.md
Name: cla_addsub_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 16-bit combinational CLA.
- Splits a WIDTH-bit operation into 4-bit lookahead groups and spreads the groups across STAGES register stages, with ripple of the group carry between stages.
- Adds a valid/ready handshake, a per-operation add/sub mode, and N/Z/V flags.
- Used by the ALU/address path where a single-cycle wide add does not close timing.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4.
- STAGES, 2, pipeline depth (latency); must divide WIDTH/4. GPS = WIDTH/4/STAGES groups are resolved per stage.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block accepts the operation this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 = A+B, 1 = A-B (computed as A + ~B + 1).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB group, before any saturation.
- flag_n  out  1  sum[WIDTH-1].
- flag_z  out  1  sum == 0.
- flag_v  out  1  signed overflow of the unsaturated operation.

Behaviour:
- Reset:
  - Clears every stage valid bit, sum, cout and all flags to 0.
  - in_ready is forced to 0 while rst = 1.
  - A reset in mid-operation discards all in-flight operations; nothing emerges afterwards.
- Advance:
  - advance = out_ready | ~out_valid, and in_ready = advance & ~rst.
  - The whole pipeline shifts only when advance = 1 (global stall); otherwise every stage holds its contents.
  - Bubbles are not collapsed.
- Accept: a transfer occurs when in_valid & in_ready. Stage 0 captures valid, the operands (b already inverted if sub) and the carry-in (= sub).
- Stage k (0..STAGES-1):
  - Resolves groups k*GPS .. k*GPS+GPS-1 with group P/G lookahead, using the carry registered from stage k-1 (stage 0 uses sub).
  - Registers those sum bits, the group carry-out, and the not-yet-added upper operand bits.
  - Already-resolved lower sum bits pass through unchanged.
- Latency: exactly STAGES cycles from acceptance to out_valid with no stall. Throughput is 1 per cycle.
- Output:
  - sum, cout and flags are registered from the final stage; they remain stable while out_valid & ~out_ready.
  - When out_valid = 0, the outputs hold their last values.
- Flags:
  - flag_v = (a[MSB] == b'[MSB]) & (raw_sum[MSB] != a[MSB]), where b' is the inverted operand when sub = 1.
  - flag_n and flag_z are taken from the final sum.
- Wrap: with no saturation, the result wraps mod 2^WIDTH. For example, 0xFFFF + 1 gives 0x0000 with cout = 1.
- Simultaneous events: accept and emit in the same cycle are legal and do not lose data. rst has priority over everything.

Optional Feature:
- Macro: CLA_SATURATE_EN.
- Defined: when flag_v = 1, sum is replaced with 0x7FF..F if a[MSB] = 0, or 0x80..0 if a[MSB] = 1. flag_n and flag_z follow the saturated sum; cout and flag_v still report the raw operation. This adds no latency.
- Undefined: the result wraps, and the saturation logic is absent.

Decomposition:
- Package cla_pkg:
  - GROUP_W = 4.
  - typedef op_mode_t (OP_ADD = 1'b0, OP_SUB = 1'b1).
  - typedef packed struct alu_flags_t {n, z, v}.
- Sub-module cla_group4: purely combinational 4-bit lookahead (a, b, cin -> sum, p, g, cout). It is instantiated WIDTH/4 times across the stages.

Test Plan:
- Defaults, no stall: a=0x1234, b=0x1111, add -> 2 cycles later sum=0x2345, cout=0, flags n=0, z=0, v=0.
- Cross-stage carry: a=0x00FF, b=0x0001 -> sum=0x0100. Separately, 0xFFFF+0x0001 -> sum=0x0000, cout=1, z=1.
- Subtract and overflow: a=0x8000, b=0x0001, sub -> sum=0x7FFF, v=1. With CLA_SATURATE_EN: sum=0x8000, n=1, v=1.
- Positive overflow: 0x7FFF+0x0001 -> without the macro sum=0x8000, v=1, n=1; with the macro sum=0x7FFF, n=0.
- Back-pressure: stream 4 ops back-to-back, hold out_ready=0 for 3 cycles once out_valid=1 -> in_ready drops, outputs are stable, and all 4 results emerge in order with none lost or duplicated.
- Reset mid-flight: accept 2 ops, assert rst for 1 cycle -> out_valid=0 and sum=0 afterwards, and neither op ever emerges.
